pipe_hazard_tracker: RTL

Parametrised hazard and forwarding tracker for the pipelined MIPS core. It holds a scoreboard of in-flight register writers for a configurable number of stages behind Decode. Each cycle it decides whether the Decode-stage instruction must stall and which stage each source operand forwards from. It also runs a busy counter for the multi-cycle multiply/divide unit and stalls HI/LO consumers until that unit is free. It supersedes the per-stage combinational Tnew/forward decode with one registered, stage-count-generic block.

---
 rtl/pipe_hazard_tracker.sv | 109 ++++++++++
 1 files changed

// File: rtl/pipe_hazard_tracker.sv
// Hazard/forwarding scoreboard for the pipelined core: tracks in-flight GPR writers
// behind Decode, derives stall and per-operand forward selects, and gates HI/LO users on the MD unit.
module pipe_hazard_tracker #(
  parameter int unsigned STAGES   = 3,
  parameter int unsigned TW       = 2,
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [4:0]                     d_rs,
  input  logic [4:0]                     d_rt,
  input  logic [TW-1:0]                  d_tuse_rs,
  input  logic [TW-1:0]                  d_tuse_rt,
  input  logic                           d_wr_en,
  input  logic [4:0]                     d_wr_addr,
  input  logic [TW-1:0]                  d_tnew,
  input  logic                           d_md_start,
  input  logic                           d_md_div,
  input  logic                           d_md_use,
  output logic                           stall,
  output logic [$clog2(STAGES+1)-1:0]    fwd_rs,
  output logic [$clog2(STAGES+1)-1:0]    fwd_rt,
  output logic                           md_busy
);

  localparam int unsigned FW = $clog2(STAGES + 1);
  localparam int unsigned CW = $clog2(DIV_CYC + 1);
  localparam logic [TW-1:0] TUSE_NONE = '1;

  logic [STAGES-1:0]          vld_q, vld_d;
  logic [STAGES-1:0][4:0]     addr_q, addr_d;
  logic [STAGES-1:0][TW-1:0]  tnew_q, tnew_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       stall_rs, stall_rt;

  // Youngest matching writer decides; result is {stall, fwd}.
  function automatic logic [FW:0] lookup(
    input logic [4:0]                r,
    input logic [TW-1:0]             tuse,
    input logic [STAGES-1:0]         vld,
    input logic [STAGES-1:0][4:0]    addr,
    input logic [STAGES-1:0][TW-1:0] tnew
  );
    logic          hit;
    logic          stl;
    logic [FW-1:0] fwd;
    hit = 1'b0;
    stl = 1'b0;
    fwd = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      if (!hit && r != 5'd0 && tuse != TUSE_NONE && vld[i] && addr[i] == r) begin
        hit = 1'b1;
        stl = tnew[i] > tuse;
        fwd = (tnew[i] == '0) ? FW'(i + 1) : '0;
      end
    end
    return {stl, fwd};
  endfunction

  always_comb begin
    {stall_rs, fwd_rs} = lookup(d_rs, d_tuse_rs, vld_q, addr_q, tnew_q);
    {stall_rt, fwd_rt} = lookup(d_rt, d_tuse_rt, vld_q, addr_q, tnew_q);
    md_busy            = (cnt_q != '0);
    stall              = stall_rs | stall_rt | (d_md_use & md_busy);
  end

  // Older entries always advance with a saturating Tnew decrement; entry 0 takes D or a bubble.
  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    tnew_d = tnew_q;
    cnt_d  = cnt_q;
    for (int i = 1; i < int'(STAGES); i++) begin
      vld_d[i]  = vld_q[i-1];
      addr_d[i] = addr_q[i-1];
      tnew_d[i] = (tnew_q[i-1] == '0) ? '0 : tnew_q[i-1] - TW'(1);
    end
    if (stall) begin
      vld_d[0]  = 1'b0;
      addr_d[0] = 5'd0;
      tnew_d[0] = '0;
    end else begin
      vld_d[0]  = d_wr_en && (d_wr_addr != 5'd0);
      addr_d[0] = d_wr_addr;
      tnew_d[0] = d_tnew;
    end
    if (d_md_start && !stall) begin
      cnt_d = d_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q  <= '0;
      addr_q <= '0;
      tnew_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
      tnew_q <= tnew_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
